// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG request scheduler: FSM states, default seed
// and the requester-index width helper.
package prng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESEED,
    WARM,
    ISSUE,
    WAIT,
    DELIVER
  } state_t;

  localparam logic [31:0] DEF_SEED = 32'hDEADBEEF;

  // Bits needed to index one of n requesters (never less than one).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prng_req_sched_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr,
// wrapping modulo NREQ.
module rr_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   owner,
  output logic            valid
);

  logic [IW-1:0] cand;

  always_comb begin
    owner = '0;
    valid = 1'b0;
    cand  = rr_ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!valid && req[cand]) begin
        valid = 1'b1;
        owner = cand;
      end
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
    end
  end

endmodule

// File: rtl/prng_req_sched.sv
// Shares one seedable PRNG core between NREQ requesters with reseed/warm-up
// sequencing. Optional repetition check enabled by PRNG_REPCHECK_EN.
module prng_req_sched #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned WARMUP   = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] DEF_SEED = prng_pkg::DEF_SEED
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [31:0]     rnd_data,
  input  logic            seed_we,
  input  logic [31:0]     seed_di,
  output logic            busy,
  output logic            fault,
`ifdef PRNG_REPCHECK_EN
  output logic            rep_alarm,
`endif
  output logic            gen_seed_load,
  output logic [31:0]     gen_seed,
  output logic            gen_start,
  input  logic            gen_done,
  input  logic [31:0]     gen_data
);

  import prng_pkg::*;

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [31:0]   seed_lat;
  logic          seed_pend;
  logic [7:0]    warm_cnt;
  logic          started;
  logic [TW-1:0] tcnt;
  logic [31:0]   word;
  logic [IW-1:0] arb_owner;
  logic          arb_valid;
  logic          alarm;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .owner  (arb_owner),
    .valid  (arb_valid)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= RESEED;
      owner         <= '0;
      rr_ptr        <= '0;
      seed_lat      <= DEF_SEED;
      seed_pend     <= 1'b0;
      warm_cnt      <= '0;
      started       <= 1'b0;
      tcnt          <= '0;
      word          <= '0;
      ack           <= '0;
      rnd_data      <= '0;
      fault         <= 1'b0;
      gen_seed_load <= 1'b0;
      gen_seed      <= DEF_SEED;
      gen_start     <= 1'b0;
    end else begin
      gen_start     <= 1'b0;
      gen_seed_load <= 1'b0;
      ack           <= '0;
      unique case (state)
        RESEED: begin
          gen_seed_load <= 1'b1;
          gen_seed      <= seed_lat;
          seed_pend     <= 1'b0;
          warm_cnt      <= 8'(WARMUP);
          started       <= 1'b0;
          state         <= (WARMUP > 0) ? WARM : IDLE;
        end
        WARM: begin
          // started splits each warm-up word into a start cycle and a wait phase
          if (!started) begin
            gen_start <= 1'b1;
            started   <= 1'b1;
            tcnt      <= '0;
          end else if (gen_done) begin
            started  <= 1'b0;
            warm_cnt <= warm_cnt - 8'd1;
            if (seed_pend)
              state <= RESEED;
            else if (warm_cnt == 8'd1)
              state <= IDLE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            fault   <= 1'b1;
            started <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        IDLE: begin
          if (seed_pend) begin
            state <= RESEED;
          end else if (arb_valid && !alarm) begin
            owner <= arb_owner;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          gen_start <= 1'b1;
          tcnt      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (gen_done) begin
            word  <= gen_data;
            state <= DELIVER;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            fault <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DELIVER: begin
          if (req[owner]) begin
            rnd_data <= word;
            ack      <= NREQ'(1) << owner;
          end
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (seed_we) begin
        seed_lat  <= seed_di;
        seed_pend <= 1'b1;
      end
    end
  end

`ifdef PRNG_REPCHECK_EN
  logic [31:0] prev_word;
  logic        have_prev;
  logic        rep_m;
  logic        take;
  logic        warm_clear;

  assign take = gen_done && ((state == WAIT) || ((state == WARM) && started));
  assign warm_clear = ((state == WARM) && started && gen_done &&
                       (warm_cnt == 8'd1) && !seed_pend) ||
                      ((state == RESEED) && (WARMUP == 0));
  assign alarm = rep_alarm;

  // A fresh seed starts a fresh history; alarm clears only once warm-up ends,
  // but a repeat detected on that final word re-arms it on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      rep_m     <= 1'b0;
      rep_alarm <= 1'b0;
    end else begin
      if (state == RESEED) begin
        have_prev <= 1'b0;
        rep_m     <= 1'b0;
      end
      if (warm_clear)
        rep_alarm <= 1'b0;
      if (take) begin
        prev_word <= gen_data;
        have_prev <= 1'b1;
        if (have_prev && (gen_data == prev_word)) begin
          if (rep_m)
            rep_alarm <= 1'b1;
          rep_m <= 1'b1;
        end else begin
          rep_m <= 1'b0;
        end
      end
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_prng_req_sched.sv
// Directed bench for prng_req_sched with a counter-echo PRNG core model.
module tb_prng_req_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic [31:0] rnd_data;
  logic        seed_we;
  logic [31:0] seed_di;
  logic        busy;
  logic        fault;
`ifdef PRNG_REPCHECK_EN
  logic        rep_alarm;
`endif
  logic        gen_seed_load;
  logic [31:0] gen_seed;
  logic        gen_start;
  logic        gen_done;
  logic [31:0] gen_data;

  always #5 clk = ~clk;

  prng_req_sched #(
    .NREQ     (2),
    .WARMUP   (4),
    .TIMEOUT  (64),
    .DEF_SEED (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req           (req),
    .ack           (ack),
    .rnd_data      (rnd_data),
    .seed_we       (seed_we),
    .seed_di       (seed_di),
    .busy          (busy),
    .fault         (fault),
`ifdef PRNG_REPCHECK_EN
    .rep_alarm     (rep_alarm),
`endif
    .gen_seed_load (gen_seed_load),
    .gen_seed      (gen_seed),
    .gen_start     (gen_start),
    .gen_done      (gen_done),
    .gen_data      (gen_data)
  );

  // Core model: answers one cycle after gen_start with an incrementing word.
  logic        core_en;
  logic        core_fixed;
  logic [31:0] next_word;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_done  <= 1'b0;
      gen_data  <= '0;
      next_word <= 32'd1;
    end else begin
      gen_done <= 1'b0;
      if (gen_start && core_en) begin
        gen_done <= 1'b1;
        if (core_fixed) begin
          gen_data <= 32'hAAAAAAAA;
        end else begin
          gen_data  <= next_word;
          next_word <= next_word + 32'd1;
        end
      end
    end
  end

  int          cyc = 0;
  int          n_start = 0;
  int          n_load = 0;
  logic [31:0] last_seed = '0;
  logic [1:0]  ack_v[$];
  logic [31:0] ack_d[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (gen_start) n_start++;
    if (gen_seed_load) begin
      n_load++;
      last_seed = gen_seed;
    end
    if (ack != 2'b00) begin
      ack_v.push_back(ack);
      ack_d.push_back(rnd_data);
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] av(input int i);
    return (i < ack_v.size()) ? 32'(ack_v[i]) : 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] ad(input int i);
    return (i < ack_d.size()) ? ack_d[i] : 32'hFFFFFFFF;
  endfunction

  initial begin
    int k;
    int s0;
    int t0;
    resetn = 1'b0;
    req = 2'b00;
    seed_we = 1'b0;
    seed_di = '0;
    core_en = 1'b1;
    core_fixed = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ack", 32'(ack), 0);
    check("rst_rnd", rnd_data, 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_fault", 32'(fault), 0);
    check("rst_start", 32'(gen_start), 0);
    check("rst_load", 32'(gen_seed_load), 0);
    check("rst_seed", gen_seed, 32'hDEADBEEF);

    // Power-up reseed and warm-up (core words 1..4 discarded)
    resetn = 1'b1;
    @(negedge clk);
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    check("warm_busy", 32'(busy), 0);
    check("warm_loads", n_load, 1);
    check("warm_seed", last_seed, 32'hDEADBEEF);
    check("warm_starts", n_start, 4);
    check("warm_noack", ack_v.size(), 0);

    // Round-robin with both requesting
    req = 2'b11;
    k = 0;
    while (ack_v.size() < 4 && k < 200) begin @(negedge clk); k++; end
    req = 2'b00;
    check("rr_ack0", av(0), 1); check("rr_dat0", ad(0), 5);
    check("rr_ack1", av(1), 2); check("rr_dat1", ad(1), 6);
    check("rr_ack2", av(2), 1); check("rr_dat2", ad(2), 7);
    check("rr_ack3", av(3), 2); check("rr_dat3", ad(3), 8);

    // Seed write while waiting on req0's word
    req = 2'b11;
    k = 0;
    while (!gen_start && k < 50) begin @(negedge clk); k++; end
    check("sw_start_seen", 32'(gen_start), 1);
    seed_di = 32'h12345678;
    seed_we = 1'b1;
    @(negedge clk);
    seed_we = 1'b0;
    k = 0;
    while (ack_v.size() < 5 && k < 100) begin @(negedge clk); k++; end
    req = 2'b10;
    s0 = n_start;
    check("sw_ack0", av(4), 1);
    check("sw_dat0", ad(4), 9);
    k = 0;
    while (ack_v.size() < 6 && k < 200) begin @(negedge clk); k++; end
    req = 2'b00;
    check("sw_ack1", av(5), 2);
    check("sw_dat1", ad(5), 14);
    check("sw_loads", n_load, 2);
    check("sw_seed", last_seed, 32'h12345678);
    check("sw_starts", n_start - s0, 5);

    // req0 withdrawn before delivery: word dropped, pointer still advances
    req = 2'b01;
    k = 0;
    while (!gen_done && k < 50) begin @(negedge clk); k++; end
    check("drop_done_seen", 32'(gen_done), 1);
    req = 2'b00;
    repeat (10) @(negedge clk);
    check("drop_noack", ack_v.size(), 6);
    check("drop_rnd", rnd_data, 14);
    check("drop_idle", 32'(busy), 0);
    req = 2'b11;
    k = 0;
    while (ack_v.size() < 7 && k < 100) begin @(negedge clk); k++; end
    req = 2'b00;
    check("drop_next_ack", av(6), 2);
    check("drop_next_dat", ad(6), 16);

    // Core never answers: timeout fault 64 cycles after gen_start
    core_en = 1'b0;
    req = 2'b01;
    k = 0;
    while (!gen_start && k < 50) begin @(negedge clk); k++; end
    t0 = cyc;
    k = 0;
    while (!fault && k < 200) begin @(negedge clk); k++; end
    check("to_fault", 32'(fault), 1);
    check("to_cycles", cyc - t0, 64);
    check("to_idle", 32'(busy), 0);
    req = 2'b00;
    s0 = n_start;
    repeat (5) @(negedge clk);
    check("to_nostart", n_start, s0);
    core_en = 1'b1;
    req = 2'b01;
    k = 0;
    while (ack_v.size() < 8 && k < 100) begin @(negedge clk); k++; end
    req = 2'b00;
    check("to_recover_ack", av(7), 1);
    check("to_recover_dat", ad(7), 17);
    check("to_sticky", 32'(fault), 1);

`ifdef PRNG_REPCHECK_EN
    // Three identical words raise rep_alarm; a reseed clears it after warm-up
    core_fixed = 1'b1;
    req = 2'b11;
    k = 0;
    while (ack_v.size() < 11 && k < 200) begin @(negedge clk); k++; end
    check("rep_dat", ad(10), 32'hAAAAAAAA);
    check("rep_alarm", 32'(rep_alarm), 1);
    s0 = n_start;
    repeat (20) @(negedge clk);
    check("rep_noack", ack_v.size(), 11);
    check("rep_nostart", n_start, s0);
    core_fixed = 1'b0;
    seed_di = 32'h0BADF00D;
    seed_we = 1'b1;
    @(negedge clk);
    seed_we = 1'b0;
    k = 0;
    while (ack_v.size() < 12 && k < 200) begin @(negedge clk); k++; end
    req = 2'b00;
    check("rep_cleared", 32'(rep_alarm), 0);
    check("rep_seed", last_seed, 32'h0BADF00D);
    check("rep_ack", av(11), 1);
    check("rep_ack_dat", ad(11), 22);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
